ffe_seq_ctrl: RTL and testbench

- Sequencer and coefficient manager for the 21-tap S(8,7) FFE.
- Generates the FFE clock-enable/valid strobes at the symbol rate from an oversampled clock and tracks pipeline warm-up.
- Holds a double-buffered coefficient bank: software writes the shadow bank; the active bank is swapped only on a symbol boundary.
- Sits between the register interface/control plane and the FFE datapath; drives the FFE's enable, valid and coefficient inputs.

---
 rtl/ffe_ctrl_pkg.sv | 28 ++
 rtl/ffe_seq_ctrl_if.sv | 34 +++
 rtl/ffe_strobe_gen.sv | 54 +++++
 rtl/ffe_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_ffe_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ffe_ctrl_pkg.sv
// ============================================================================
// Module   : ffe_ctrl_pkg
// Purpose  : Shared state encoding and sizing helpers for the FFE sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ffe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Width of a counter spanning 0..n-1 (never narrower than one bit)
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Largest positive value of an S(x, nbf) coefficient, 0x7F for nbf = 7
  function automatic int rst_coeff(input int nbf);
    return (1 << nbf) - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ffe_seq_ctrl_if.sv
// ============================================================================
// Module   : ffe_seq_ctrl_if
// Purpose  : Coefficient write / commit bus between control plane and sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ffe_seq_ctrl_if #(
  parameter int NB_ADDR  = 5,
  parameter int NB_COEFF = 8
) ();

  logic                coeff_wr;
  logic [NB_ADDR-1:0]  coeff_addr;
  logic [NB_COEFF-1:0] coeff_data;
  logic                coeff_commit;
  logic                coeff_ack;
  logic                coeff_err;
  logic                coeff_busy;
  logic                commit_done;

  modport master (
    output coeff_wr, coeff_addr, coeff_data, coeff_commit,
    input  coeff_ack, coeff_err, coeff_busy, commit_done
  );

  modport slave (
    input  coeff_wr, coeff_addr, coeff_data, coeff_commit,
    output coeff_ack, coeff_err, coeff_busy, commit_done
  );

endinterface

`default_nettype wire

// File: rtl/ffe_strobe_gen.sv
// ============================================================================
// Module   : ffe_strobe_gen
// Purpose  : Symbol-rate divider with phase match and registered en/valid strobes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ffe_strobe_gen
  import ffe_ctrl_pkg::*;
#(
  parameter  int OS_FACTOR = 4,
  localparam int NB_CNT    = cnt_w(OS_FACTOR)
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic [NB_CNT-1:0] i_phase,
  input  logic              i_valid,
  output logic              o_match,
  output logic              o_fir_en,
  output logic              o_fir_valid
);

  logic [NB_CNT-1:0] cnt_q, cnt_d;
  logic              fir_en_q, fir_valid_q;

  // Dropping the enable clears the divider so every restart has the same phase
  always_comb begin
    cnt_d = '0;
    if (i_en) begin
      cnt_d = (cnt_q == NB_CNT'(OS_FACTOR - 1)) ? '0 : cnt_q + 1'b1;
    end
  end

  assign o_match = i_en && (cnt_q == i_phase);

  always_ff @(posedge clk) begin
    if (!i_reset) begin
      cnt_q       <= '0;
      fir_en_q    <= 1'b0;
      fir_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      fir_en_q    <= o_match;
      fir_valid_q <= o_match & i_valid;
    end
  end

  assign o_fir_en    = fir_en_q;
  assign o_fir_valid = fir_valid_q;

endmodule

`default_nettype wire

// File: rtl/ffe_seq_ctrl.sv
// ============================================================================
// Module   : ffe_seq_ctrl
// Purpose  : FFE sequencer (warm-up tracking) and double-buffered coefficient bank.
//            Optional macro FFE_SWAP_REFILL_EN: a swap in RUN re-enters FILL.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ffe_seq_ctrl
  import ffe_ctrl_pkg::*;
#(
  parameter int FIR_LEN    = 21,
  parameter int NB_COEFF   = 8,
  parameter int NBF_COEFF  = 7,
  parameter int OS_FACTOR  = 4,
  parameter int CENTER_TAP = 10,
  parameter int NB_ADDR    = 5
) (
  input  logic                          clk,
  input  logic                          i_reset,
  input  logic                          i_run,
  input  logic [cnt_w(OS_FACTOR)-1:0]   i_phase,
  input  logic                          i_valid,
  ffe_seq_ctrl_if.slave                 coeff_bus,
  output logic [FIR_LEN*NB_COEFF-1:0]   o_coeff_flat,
  output logic                          o_fir_en,
  output logic                          o_fir_valid,
  output logic                          o_out_valid,
  output logic [1:0]                    o_state
);

  localparam int                  NB_FILL     = cnt_w(FIR_LEN);
  localparam logic [NB_COEFF-1:0] C_RST_COEFF = NB_COEFF'(rst_coeff(NBF_COEFF));

  state_e              state_q, state_d;
  logic [NB_FILL-1:0]  fill_q, fill_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic                ack_q, err_q, done_q;
  logic [NB_COEFF-1:0] shadow_q [FIR_LEN];
  logic [NB_COEFF-1:0] active_q [FIR_LEN];

  logic w_strobe_en, w_match, w_addr_ok, w_wr_ok, w_wr_bad, w_swap;

  assign w_strobe_en = (state_q != ST_IDLE) && i_run;

  ffe_strobe_gen #(
    .OS_FACTOR (OS_FACTOR)
  ) u_strobe (
    .clk         (clk),
    .i_reset     (i_reset),
    .i_en        (w_strobe_en),
    .i_phase     (i_phase),
    .i_valid     (i_valid),
    .o_match     (w_match),
    .o_fir_en    (o_fir_en),
    .o_fir_valid (o_fir_valid)
  );

  assign w_addr_ok = coeff_bus.coeff_addr < NB_ADDR'(FIR_LEN);
  assign w_wr_ok   = coeff_bus.coeff_wr && !busy_q && w_addr_ok;
  assign w_wr_bad  = coeff_bus.coeff_wr && !busy_q && !w_addr_ok;
  // Busy blocks writes, so shadow is stable for the whole pending window
  assign w_swap    = busy_q && ((state_q == ST_IDLE) || w_match);
  assign busy_d    = busy_q ? !w_swap : coeff_bus.coeff_commit;

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    if (!i_run) begin
      state_d = ST_IDLE;
      fill_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_FILL;
          fill_d  = '0;
        end
        ST_FILL: begin
          if (w_match) begin
            if (fill_q == NB_FILL'(FIR_LEN - 1)) begin
              state_d = ST_RUN;
              fill_d  = '0;
            end else begin
              fill_d = fill_q + 1'b1;
            end
          end
        end
        ST_RUN: begin
`ifdef FFE_SWAP_REFILL_EN
          if (w_swap) begin
            state_d = ST_FILL;
            fill_d  = '0;
          end
`endif
        end
        default: begin
          state_d = ST_IDLE;
          fill_d  = '0;
        end
      endcase
    end
    out_valid_d = (state_q == ST_RUN) && (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!i_reset) begin
      state_q     <= ST_IDLE;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      ack_q       <= w_wr_ok;
      err_q       <= w_wr_bad;
      done_q      <= w_swap;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_reset) begin
      for (int k = 0; k < FIR_LEN; k++) begin
        shadow_q[k] <= (k == CENTER_TAP) ? C_RST_COEFF : '0;
        active_q[k] <= (k == CENTER_TAP) ? C_RST_COEFF : '0;
      end
    end else begin
      if (w_wr_ok) begin
        shadow_q[coeff_bus.coeff_addr] <= coeff_bus.coeff_data;
      end
      if (w_swap) begin
        active_q <= shadow_q;
      end
    end
  end

  for (genvar k = 0; k < FIR_LEN; k++) begin : g_flat
    assign o_coeff_flat[k*NB_COEFF +: NB_COEFF] = active_q[k];
  end

  assign coeff_bus.coeff_ack   = ack_q;
  assign coeff_bus.coeff_err   = err_q;
  assign coeff_bus.coeff_busy  = busy_q;
  assign coeff_bus.commit_done = done_q;
  assign o_out_valid           = out_valid_q;
  assign o_state               = state_q;

endmodule

`default_nettype wire

// File: tb/tb_ffe_seq_ctrl.sv
// ============================================================================
// Module   : tb_ffe_seq_ctrl
// Purpose  : Directed self-checking bench for ffe_seq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ffe_seq_ctrl;

  localparam int FIR_LEN  = 21;
  localparam int NB_COEFF = 8;
  localparam int FW       = FIR_LEN * NB_COEFF;

  logic          clk = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_run = 1'b0;
  logic          i_valid = 1'b0;
  logic [1:0]    i_phase = 2'd0;
  logic [FW-1:0] o_coeff_flat;
  logic          o_fir_en, o_fir_valid, o_out_valid;
  logic [1:0]    o_state;

  int total = 0;
  int bad   = 0;
  logic [FW-1:0] exp_flat;

  ffe_seq_ctrl_if #(.NB_ADDR(5), .NB_COEFF(NB_COEFF)) bus ();

  ffe_seq_ctrl #(
    .FIR_LEN(FIR_LEN), .NB_COEFF(NB_COEFF), .NBF_COEFF(7),
    .OS_FACTOR(4), .CENTER_TAP(10), .NB_ADDR(5)
  ) dut (
    .clk          (clk),
    .i_reset      (i_reset),
    .i_run        (i_run),
    .i_phase      (i_phase),
    .i_valid      (i_valid),
    .coeff_bus    (bus),
    .o_coeff_flat (o_coeff_flat),
    .o_fir_en     (o_fir_en),
    .o_fir_valid  (o_fir_valid),
    .o_out_valid  (o_out_valid),
    .o_state      (o_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_en(output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n++;
      if (o_fir_en) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.coeff_wr = 1'b0; bus.coeff_addr = '0; bus.coeff_data = '0; bus.coeff_commit = 1'b0;
    i_reset = 1'b0;
    repeat (3) tick();
    exp_flat = '0;
    exp_flat[10*NB_COEFF +: NB_COEFF] = 8'h7F;
    total++; if (o_state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", o_state); end
    total++; if (o_fir_en !== 1'b0 || o_fir_valid !== 1'b0) begin bad++; $display("FAIL rst_strobe got=%b%b want=00", o_fir_en, o_fir_valid); end
    total++; if (o_out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", o_out_valid); end
    total++; if ({bus.coeff_busy, bus.coeff_ack, bus.coeff_err, bus.commit_done} !== 4'b0) begin bad++; $display("FAIL rst_bus got=%b want=0000", {bus.coeff_busy, bus.coeff_ack, bus.coeff_err, bus.commit_done}); end
    total++; if (o_coeff_flat !== exp_flat) begin bad++; $display("FAIL rst_flat got=%h want=%h", o_coeff_flat, exp_flat); end
    i_reset = 1'b1;
    tick();
    total++; if (o_state !== 2'd0) begin bad++; $display("FAIL idle_hold got=%0d want=0", o_state); end
  endtask

  task automatic test_fill_run();
    int strobes = 0;
    int bad_lat = 0;
    int bad_ov = 0;
    i_phase = 2'd2; i_valid = 1'b1; i_run = 1'b1;
    for (int t = 1; t <= 200; t++) begin
      tick();
      if (o_out_valid !== 1'b0) bad_ov++;
      if (o_fir_en) begin
        strobes++;
        if (t != 4 * strobes || o_fir_valid !== 1'b1) bad_lat++;
      end
      if (strobes == FIR_LEN) break;
    end
    total++; if (strobes != FIR_LEN) begin bad++; $display("FAIL fill_timeout got=%0d want=%0d strobes", strobes, FIR_LEN); end
    total++; if (bad_lat != 0) begin bad++; $display("FAIL strobe_timing got=%0d bad strobes want=0", bad_lat); end
    total++; if (bad_ov != 0) begin bad++; $display("FAIL fill_out_valid got=%0d high cycles want=0", bad_ov); end
    total++; if (o_state !== 2'd2) begin bad++; $display("FAIL run_entry got=%0d want=2", o_state); end
    tick();
    total++; if (o_out_valid !== 1'b1) begin bad++; $display("FAIL out_valid_rise got=%b want=1", o_out_valid); end
    total++; if (o_coeff_flat !== exp_flat) begin bad++; $display("FAIL run_flat got=%h want=%h", o_coeff_flat, exp_flat); end
  endtask

  task automatic test_alt_valid();
    bit pat [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    bit ok;
    int n;
    wait_en(ok, n);
    total++; if (!ok) begin bad++; $display("FAIL alt_sync got=timeout want=strobe"); end
    for (int k = 0; k < 4; k++) begin
      i_valid = pat[k];
      wait_en(ok, n);
      total++; if (!ok || n != 4) begin bad++; $display("FAIL alt_en[%0d] got=%0d cycles want=4", k, n); end
      total++; if (o_fir_valid !== pat[k]) begin bad++; $display("FAIL alt_valid[%0d] got=%b want=%b", k, o_fir_valid, pat[k]); end
    end
    i_valid = 1'b1;
    total++; if (o_out_valid !== 1'b1) begin bad++; $display("FAIL alt_out_valid got=%b want=1", o_out_valid); end
  endtask

  task automatic test_coeff_commit();
    logic [FW-1:0] old_flat;
    bit ok;
    int n;
    int extra;
    old_flat = exp_flat;
    bus.coeff_wr = 1'b1; bus.coeff_addr = 5'd4; bus.coeff_data = 8'h2C;
    tick();
    total++; if (bus.coeff_ack !== 1'b1 || bus.coeff_err !== 1'b0) begin bad++; $display("FAIL wr4_ack got=%b%b want=10", bus.coeff_ack, bus.coeff_err); end
    bus.coeff_addr = 5'd9; bus.coeff_data = 8'h80;
    tick();
    bus.coeff_wr = 1'b0;
    total++; if (bus.coeff_ack !== 1'b1) begin bad++; $display("FAIL wr9_ack got=%b want=1", bus.coeff_ack); end
    total++; if (o_coeff_flat !== old_flat) begin bad++; $display("FAIL shadow_only got=%h want=%h", o_coeff_flat, old_flat); end
    exp_flat[4*NB_COEFF +: NB_COEFF] = 8'h2C;
    exp_flat[9*NB_COEFF +: NB_COEFF] = 8'h80;
    wait_en(ok, n);
    total++; if (!ok) begin bad++; $display("FAIL commit_sync got=timeout want=strobe"); end
    bus.coeff_commit = 1'b1;
    tick();
    bus.coeff_commit = 1'b0;
    total++; if (bus.coeff_busy !== 1'b1 || bus.commit_done !== 1'b0) begin bad++; $display("FAIL commit_busy got=%b%b want=10", bus.coeff_busy, bus.commit_done); end
    bus.coeff_wr = 1'b1; bus.coeff_addr = 5'd3; bus.coeff_data = 8'h11;
    tick();
    bus.coeff_wr = 1'b0;
    total++; if (bus.coeff_ack !== 1'b0 || bus.coeff_err !== 1'b0) begin bad++; $display("FAIL busy_write got=%b%b want=00", bus.coeff_ack, bus.coeff_err); end
    tick();
    total++; if (o_coeff_flat !== old_flat || bus.commit_done !== 1'b0) begin bad++; $display("FAIL pre_swap got=%h want=%h", o_coeff_flat, old_flat); end
    tick();
    total++; if (bus.commit_done !== 1'b1 || bus.coeff_busy !== 1'b0 || o_fir_en !== 1'b1) begin bad++; $display("FAIL swap_pulse got=%b%b%b want=101", bus.commit_done, bus.coeff_busy, o_fir_en); end
    total++; if (o_coeff_flat !== exp_flat) begin bad++; $display("FAIL swap_flat got=%h want=%h", o_coeff_flat, exp_flat); end
`ifdef FFE_SWAP_REFILL_EN
    total++; if (o_state !== 2'd1 || o_out_valid !== 1'b0) begin bad++; $display("FAIL refill_entry got=%0d/%b want=1/0", o_state, o_out_valid); end
    extra = 0;
    for (int k = 1; k <= FIR_LEN; k++) begin
      wait_en(ok, n);
      if (!ok || o_out_valid !== 1'b0 || (k < FIR_LEN && o_state !== 2'd1)) extra++;
    end
    total++; if (extra != 0 || o_state !== 2'd2) begin bad++; $display("FAIL refill_run got=%0d errs state=%0d want=0 errs state=2", extra, o_state); end
    tick();
    total++; if (o_out_valid !== 1'b1) begin bad++; $display("FAIL refill_out_valid got=%b want=1", o_out_valid); end
`else
    total++; if (o_state !== 2'd2 || o_out_valid !== 1'b1) begin bad++; $display("FAIL swap_keep_run got=%0d/%b want=2/1", o_state, o_out_valid); end
    extra = 0;
    repeat (8) begin
      tick();
      if (bus.commit_done !== 1'b0 || o_out_valid !== 1'b1) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("FAIL done_once got=%0d bad cycles want=0", extra); end
`endif
  endtask

  task automatic test_idle_coeff();
    i_run = 1'b0;
    tick();
    total++; if (o_state !== 2'd0 || o_out_valid !== 1'b0) begin bad++; $display("FAIL drop_idle got=%0d/%b want=0/0", o_state, o_out_valid); end
    bus.coeff_wr = 1'b1; bus.coeff_addr = 5'd21; bus.coeff_data = 8'h55;
    tick();
    bus.coeff_wr = 1'b0;
    total++; if (bus.coeff_err !== 1'b1 || bus.coeff_ack !== 1'b0) begin bad++; $display("FAIL addr_err got=%b%b want=10", bus.coeff_err, bus.coeff_ack); end
    tick();
    total++; if (bus.coeff_err !== 1'b0 || o_fir_en !== 1'b0) begin bad++; $display("FAIL err_pulse got=%b want=0", bus.coeff_err); end
    bus.coeff_wr = 1'b1; bus.coeff_addr = 5'd0; bus.coeff_data = 8'h01;
    tick();
    bus.coeff_addr = 5'd20; bus.coeff_data = 8'h7E; bus.coeff_commit = 1'b1;
    tick();
    bus.coeff_wr = 1'b0; bus.coeff_commit = 1'b0;
    total++; if (bus.coeff_ack !== 1'b1 || bus.coeff_busy !== 1'b1 || bus.commit_done !== 1'b0) begin bad++; $display("FAIL wr_commit got=%b%b%b want=110", bus.coeff_ack, bus.coeff_busy, bus.commit_done); end
    exp_flat[0*NB_COEFF +: NB_COEFF]  = 8'h01;
    exp_flat[20*NB_COEFF +: NB_COEFF] = 8'h7E;
    tick();
    total++; if (bus.commit_done !== 1'b1 || bus.coeff_busy !== 1'b0) begin bad++; $display("FAIL idle_swap got=%b%b want=10", bus.commit_done, bus.coeff_busy); end
    total++; if (o_coeff_flat !== exp_flat) begin bad++; $display("FAIL idle_flat got=%h want=%h", o_coeff_flat, exp_flat); end
  endtask

  task automatic test_run_drop();
    bit ok;
    int n;
    int errs = 0;
    i_run = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wait_en(ok, n);
      if (!ok) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL drop_prefill got=%0d timeouts want=0", errs); end
    i_run = 1'b0;
    tick();
    total++; if (o_state !== 2'd0 || o_out_valid !== 1'b0 || o_fir_en !== 1'b0) begin bad++; $display("FAIL drop_fill got=%0d want=0", o_state); end
    tick();
    i_run = 1'b1;
    wait_en(ok, n);
    total++; if (!ok || n != 4) begin bad++; $display("FAIL restart_latency got=%0d want=4", n); end
    errs = 0;
    for (int k = 2; k <= FIR_LEN; k++) begin
      if (o_state !== 2'd1 || o_out_valid !== 1'b0) errs++;
      wait_en(ok, n);
      if (!ok) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL refill_len got=%0d errs want=0", errs); end
    total++; if (o_state !== 2'd2) begin bad++; $display("FAIL refill_state got=%0d want=2", o_state); end
    tick();
    total++; if (o_out_valid !== 1'b1) begin bad++; $display("FAIL refill_valid got=%b want=1", o_out_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill_run();
    test_alt_valid();
    test_coeff_commit();
    test_idle_coeff();
    test_run_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
